// File: rtl/qupls4_rd_alloc.sv
// Destination register allocator: circular free list of physical registers.
// Hands out up to two pregs per decode group, takes back up to two at commit,
// and supports a single branch checkpoint of the free-list head.
module qupls4_rd_alloc #(
  parameter int unsigned NPREG = 64,
  parameter int unsigned NINIT = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [1:0]                   in_need,
  output logic                         in_ready,
  output logic [$clog2(NPREG)-1:0]     alloc_preg0,
  output logic [$clog2(NPREG)-1:0]     alloc_preg1,
  input  logic [1:0]                   free_valid,
  input  logic [$clog2(NPREG)-1:0]     free_preg0,
  input  logic [$clog2(NPREG)-1:0]     free_preg1,
  input  logic                         ckpt_save,
  input  logic                         ckpt_restore,
  output logic [$clog2(NPREG):0]       free_count,
  output logic                         err
);

  localparam int unsigned PW = $clog2(NPREG);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] list_q [NPREG];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] ckpt_q, ckpt_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [1:0]    need;
  logic          fire;
  logic [PW-1:0] head_p1;

  logic          wr0_en, wr1_en;
  logic [PW-1:0] wr0_idx, wr1_idx;
  logic [PW-1:0] wr0_data, wr1_data;

  // Pointer increment with wrap at NPREG (works for non power-of-two sizes).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [CW-1:0] s;
    s = CW'(p) + CW'(n);
    if (s >= CW'(NPREG)) s = s - CW'(NPREG);
    return PW'(s);
  endfunction

  // Group acceptance and combinational allocation results.
  always_comb begin
    need     = {1'b0, in_need[0]} + {1'b0, in_need[1]};
    in_ready = (count_q >= CW'(need)) & ~ckpt_restore;
    fire     = in_valid & in_ready;
    head_p1  = ptr_add(head_q, 2'd1);
    alloc_preg0 = '0;
    alloc_preg1 = '0;
    case (in_need)
      2'b11: begin
        alloc_preg0 = list_q[head_q];
        alloc_preg1 = list_q[head_p1];
      end
      2'b01: alloc_preg0 = list_q[head_q];
      2'b10: alloc_preg1 = list_q[head_q];
      default: ;
    endcase
  end

  // Next-state: head/tail/count/checkpoint/error and free-list writes.
  always_comb begin
    logic [CW-1:0] running;
    logic [CW-1:0] diff;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_idx  = '0;
    wr1_idx  = '0;
    wr0_data = '0;
    wr1_data = '0;
    err_d    = err_q;
    tail_d   = tail_q;
    head_d   = head_q;
    ckpt_d   = ckpt_q;
    diff     = '0;
    running  = count_q - (fire ? CW'(need) : CW'(0));

    if (fire) head_d = ptr_add(head_q, need);

    // Appends in port order; zero register is dropped, overflow is dropped and flagged.
    if (free_valid[0] && (free_preg0 != '0)) begin
      if (running >= CW'(NPREG - 1)) begin
        err_d = 1'b1;
      end else begin
        wr0_en   = 1'b1;
        wr0_idx  = tail_d;
        wr0_data = free_preg0;
        tail_d   = ptr_add(tail_d, 2'd1);
        running  = running + CW'(1);
      end
    end
    if (free_valid[1] && (free_preg1 != '0)) begin
      if (running >= CW'(NPREG - 1)) begin
        err_d = 1'b1;
      end else begin
        wr1_en   = 1'b1;
        wr1_idx  = tail_d;
        wr1_data = free_preg1;
        tail_d   = ptr_add(tail_d, 2'd1);
        running  = running + CW'(1);
      end
    end
    count_d = running;

    if (ckpt_save) ckpt_d = head_d;

    // Restore wins over save; count is rebuilt from the distance tail_next - ckpt.
    if (ckpt_restore) begin
      head_d = ckpt_q;
      ckpt_d = ckpt_q;
      if (tail_d >= ckpt_q) diff = CW'(tail_d) - CW'(ckpt_q);
      else                  diff = CW'(tail_d) + CW'(NPREG) - CW'(ckpt_q);
      if ((diff == '0) && (count_q != '0)) count_d = CW'(NPREG);
      else                                 count_d = diff;
    end
  end

  // Pointer, count, checkpoint and error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= PW'(NPREG - NINIT);
      count_q <= CW'(NPREG - NINIT);
      ckpt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ckpt_q  <= ckpt_d;
      err_q   <= err_d;
    end
  end

  // Free-list storage; reset preloads the registers not architecturally mapped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NPREG; i++)
        list_q[i] <= (i < NPREG - NINIT) ? PW'(NINIT + i) : '0;
    end else begin
      if (wr0_en) list_q[wr0_idx] <= wr0_data;
      if (wr1_en) list_q[wr1_idx] <= wr1_data;
    end
  end

  assign free_count = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_qupls4_rd_alloc.sv
// Directed table-driven bench for qupls4_rd_alloc with default parameters.
module tb_qupls4_rd_alloc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_need;
  logic       in_ready;
  logic [5:0] alloc_preg0, alloc_preg1;
  logic [1:0] free_valid;
  logic [5:0] free_preg0, free_preg1;
  logic       ckpt_save, ckpt_restore;
  logic [6:0] free_count;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qupls4_rd_alloc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_need(in_need),
    .in_ready(in_ready), .alloc_preg0(alloc_preg0), .alloc_preg1(alloc_preg1),
    .free_valid(free_valid), .free_preg0(free_preg0), .free_preg1(free_preg1),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
    .free_count(free_count), .err(err)
  );

  typedef struct {
    logic       v;
    logic [1:0] need;
    logic [1:0] fv;
    logic [5:0] f0, f1;
    logic       sv, rs;
    logic       e_rdy;
    logic [5:0] e_p0, e_p1;
    logic [6:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic v, input logic [1:0] need, input logic [1:0] fv,
                              input logic [5:0] f0, input logic [5:0] f1, input logic sv,
                              input logic rs, input logic e_rdy, input logic [5:0] e_p0,
                              input logic [5:0] e_p1, input logic [6:0] e_cnt, input logic e_err);
    vec_t r;
    r.v = v; r.need = need; r.fv = fv; r.f0 = f0; r.f1 = f1; r.sv = sv; r.rs = rs;
    r.e_rdy = e_rdy; r.e_p0 = e_p0; r.e_p1 = e_p1; r.e_cnt = e_cnt; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_need = 2'b00; free_valid = 2'b00;
    free_preg0 = '0; free_preg1 = '0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
  endtask

  // Reset while other inputs are active, then confirm the reset state.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; in_need = 2'b11; free_valid = 2'b11;
    free_preg0 = 6'd5; free_preg1 = 6'd6; ckpt_save = 1'b1; ckpt_restore = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    chk({tag, " reset count"}, int'(free_count), 32);
    chk({tag, " reset err"}, int'(err), 0);
  endtask

  // Apply one vector: combinational checks before the edge, registered after.
  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    in_valid = t.v; in_need = t.need; free_valid = t.fv;
    free_preg0 = t.f0; free_preg1 = t.f1; ckpt_save = t.sv; ckpt_restore = t.rs;
    #1;
    chk({tag, " ready"}, int'(in_ready), int'(t.e_rdy));
    chk({tag, " preg0"}, int'(alloc_preg0), int'(t.e_p0));
    chk({tag, " preg1"}, int'(alloc_preg1), int'(t.e_p1));
    @(posedge clk);
    #1;
    chk({tag, " count"}, int'(free_count), int'(t.e_cnt));
    chk({tag, " err"}, int'(err), int'(t.e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    idle();
    //             v  need   fv     f0  f1  sv rs  rdy p0  p1  cnt err
    tbl[0]  = mk(1, 2'b11, 2'b00, 0,  0,  0, 0,  1, 32, 33, 30, 0);
    tbl[1]  = mk(1, 2'b01, 2'b00, 0,  0,  0, 0,  1, 34, 0,  29, 0);
    tbl[2]  = mk(1, 2'b10, 2'b00, 0,  0,  0, 0,  1, 0,  35, 28, 0);
    tbl[3]  = mk(1, 2'b00, 2'b00, 0,  0,  0, 0,  1, 0,  0,  28, 0);
    tbl[4]  = mk(0, 2'b11, 2'b00, 0,  0,  0, 0,  1, 36, 37, 28, 0);
    tbl[5]  = mk(0, 2'b01, 2'b11, 0,  40, 0, 0,  1, 36, 0,  29, 0);
    tbl[6]  = mk(1, 2'b11, 2'b01, 7,  0,  0, 0,  1, 36, 37, 28, 0);
    tbl[7]  = mk(1, 2'b01, 2'b00, 0,  0,  1, 0,  1, 38, 0,  27, 0);
    tbl[8]  = mk(1, 2'b11, 2'b00, 0,  0,  0, 0,  1, 39, 40, 25, 0);
    tbl[9]  = mk(1, 2'b01, 2'b10, 0,  9,  0, 1,  0, 41, 0,  28, 0);
    tbl[10] = mk(1, 2'b11, 2'b00, 0,  0,  0, 0,  1, 39, 40, 26, 0);
    tbl[11] = mk(0, 2'b00, 2'b00, 0,  0,  1, 1,  0, 0,  0,  28, 0);
    tbl[12] = mk(1, 2'b01, 2'b00, 0,  0,  0, 0,  1, 39, 0,  27, 0);
    tbl[13] = mk(0, 2'b00, 2'b00, 0,  0,  0, 1,  0, 0,  0,  28, 0);
    tbl[14] = mk(1, 2'b11, 2'b00, 0,  0,  0, 0,  1, 39, 40, 26, 0);

    do_reset("tbl");
    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // Checkpoint at head 0, allocate six, restore.
    do_reset("ckpt");
    step(mk(0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0, 32, 0), "ckpt save");
    for (int k = 0; k < 3; k++)
      step(mk(1, 2'b11, 2'b00, 0, 0, 0, 0, 1, 6'(32 + 2*k), 6'(33 + 2*k), 7'(30 - 2*k), 0),
           $sformatf("ckpt alloc%0d", k));
    step(mk(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 32, 0), "ckpt restore");
    step(mk(1, 2'b01, 2'b00, 0, 0, 0, 0, 1, 32, 0, 31, 0), "ckpt realloc");

    // Drain to one entry, then a pair request stalls while a free arrives.
    do_reset("drain");
    for (int k = 0; k < 15; k++)
      step(mk(1, 2'b11, 2'b00, 0, 0, 0, 0, 1, 6'(32 + 2*k), 6'(33 + 2*k), 7'(30 - 2*k), 0),
           $sformatf("drain%0d", k));
    step(mk(1, 2'b01, 2'b00, 0, 0, 0, 0, 1, 62, 0, 1, 0), "drain last");
    step(mk(1, 2'b11, 2'b01, 5, 0, 0, 0, 0, 63, 0, 2, 0), "drain stall");
    step(mk(1, 2'b11, 2'b00, 0, 0, 0, 0, 1, 63, 5, 0, 0), "drain resume");

    // Overfill: count saturates at 63 and err sticks until reset.
    do_reset("ovf");
    for (int k = 1; k <= 31; k++)
      step(mk(0, 2'b00, 2'b01, 6'(k), 0, 0, 0, 1, 0, 0, 7'(32 + k), 0), $sformatf("ovf fill%0d", k));
    step(mk(0, 2'b00, 2'b01, 50, 0, 0, 0, 1, 0, 0, 63, 1), "ovf extra");
    for (int k = 0; k < 3; k++)
      step(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 63, 1), $sformatf("ovf hold%0d", k));
    do_reset("ovf clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qupls4_rd_alloc.md
QUPLS4_RD_ALLOC -- requirements
Module: Qupls4_rd_alloc

Interface
REQ-001 SHALL have parameter NPREG, default 64, number of physical registers; preg 0 is the hardwired zero register and is never allocated.
REQ-002 SHALL have parameter NINIT, default 32, number of pregs (1..NINIT-1) that are architecturally mapped at reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  a decoded group of two micro-ops requests destination allocation.
REQ-006 SHALL have port in_need  input  2  per-slot allocation need: slot valid and Rdz=0.
REQ-007 SHALL have port in_ready  output  1  the allocator accepts the group this cycle.
REQ-008 SHALL have port alloc_preg0  output  6  physical register assigned to slot 0.
REQ-009 SHALL have port alloc_preg1  output  6  physical register assigned to slot 1.
REQ-010 SHALL have port free_valid  input  2  per-port release of a physical register at commit.
REQ-011 SHALL have port free_preg0  input  6  register released on port 0.
REQ-012 SHALL have port free_preg1  input  6  register released on port 1.
REQ-013 SHALL have port ckpt_save  input  1  capture the free-list head for a branch checkpoint.
REQ-014 SHALL have port ckpt_restore  input  1  roll the head back to the checkpoint on a flush.
REQ-015 SHALL have port free_count  output  7  entries currently on the free list.
REQ-016 SHALL have port err  output  1  sticky overflow/underflow error flag.

Function
REQ-017 SHALL hold the free list as an NPREG-entry circular buffer with 6-bit head and tail pointers and a 7-bit count; pointers wrap modulo NPREG.
REQ-018 SHALL compute need = popcount(in_need); fire = in_valid & in_ready.
REQ-019 SHALL drive in_ready = (free_count >= need) & ~ckpt_restore, combinationally.
REQ-020 SHALL drive alloc pregs combinationally: in_need=11 -> preg0=list[head], preg1=list[head+1]; 01 -> preg0=list[head], preg1=0; 10 -> preg0=0, preg1=list[head]; 00 -> both 0.
REQ-021 SHALL, on fire, advance head by need; need=0 fire is legal and changes no state.
REQ-022 SHALL, per cycle, append valid free ports with free_preg != 0 at tail in port order (port 0 first), advancing tail by the number appended; free_preg=0 is silently dropped.
REQ-023 SHALL update count = count - (fire ? need : 0) + appended in the same cycle, so simultaneous alloc and free net correctly, including alloc of entries freed that cycle excluded (new entries visible next cycle only).
REQ-024 SHALL, on ckpt_save, store head (post-fire value if fire in same cycle) in a checkpoint register.
REQ-025 SHALL, on ckpt_restore, set head to the checkpoint and count = (tail_next - ckpt) mod NPREG, with count = NPREG when that difference is 0 and count was nonzero before; restore overrides a same-cycle ckpt_save; frees in that cycle still apply.
REQ-026 SHALL set err and drop the excess entry if an append would make count exceed NPREG-1 (entries for pregs 1..NPREG-1 only); err stays set until reset.
REQ-027 SHALL drive free_count from the count register (registered value).

Reset
REQ-028 SHALL, on rst_n=0 at a clock edge, set list[i] = NINIT+i for i < NPREG-NINIT, head=0, tail=NPREG-NINIT, count=NPREG-NINIT, checkpoint=0, err=0.
REQ-029 SHALL give reset priority over every other input, including mid-allocation and mid-restore.

Verification
REQ-030 Reset, then in_valid=1, in_need=11 -> in_ready=1, alloc_preg0=32, alloc_preg1=33; next cycle free_count=30.
REQ-031 in_need=10 after reset -> alloc_preg0=0, alloc_preg1=32; free_count 32->31.
REQ-032 Drain to free_count=1, in_need=11 -> in_ready=0, head unchanged; same cycle free_valid=01 preg 5 -> next cycle free_count=2, in_ready=1.
REQ-033 ckpt_save at head=0, allocate 6 regs, ckpt_restore -> free_count returns to 32, next alloc_preg0=32.
REQ-034 free_valid=11 with free_preg0=0, free_preg1=40 -> only 40 appended, count +1, err=0.
REQ-035 Free 32 extra regs after reset (count reaches 63, then one more) -> err=1, count stays 63, err holds until rst_n=0.
